conv_run_controller: RTL and testbench
======================================

Name: conv_run_controller

Overview:
- Top-level sequencer for one convolution run on the 10x12 ROM image.
- Arms the convolution engine and forwards UART kernel digits to it only while a kernel is being loaded.
- Hands the engine's result-print request to the matrix printer, then sends the engine's cycle count over UART TX as decimal ASCII.
- Soft-resets the engine after every run so the engine never sits in its terminal done state. Also aborts a stalled kernel load on timeout.

Parameters:
- TIMEOUT_CYCLES, default 50000000: idle cycles allowed between kernel bytes before abort (1 s at 50 MHz; benches override it, e.g. 100).
- RST_PULSE, default 2: number of cycles eng_rst is held high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  run request; sampled only in IDLE; a 1-cycle pulse is sufficient
- uart_rx_valid  in  1  received byte strobe
- uart_rx_data  in  8  received byte
- eng_rst  out  1  engine reset
- eng_enable  out  1  engine enable pulse
- eng_rx_valid  out  1  gated byte strobe to the engine
- eng_rx_data  out  8  byte to the engine
- eng_print_enable  in  1  engine result-print request
- eng_print_done  out  1  print-complete acknowledge to the engine
- eng_cycles  in  16  engine cycles_counter_out
- prt_start  out  1  matrix printer start pulse
- prt_done  in  1  matrix printer finished (1-cycle pulse)
- tx_valid  out  1  UART TX byte valid
- tx_data  out  8  UART TX byte
- tx_ready  in  1  UART TX accepts a byte when valid and ready are both high
- busy  out  1  high in every state except IDLE
- run_done  out  1  1-cycle pulse when a run completes successfully
- err_timeout  out  1  sticky abort flag; cleared on the next accepted start

Behaviour:
- Reset values: all outputs 0, state IDLE.
- All outputs are registered except eng_rx_valid and eng_rx_data, which are combinational:
  - eng_rx_valid = uart_rx_valid AND (state == KERNEL).
  - eng_rx_data = uart_rx_data.
- States and transitions:
  - IDLE:
    - On start: eng_enable = 1 for exactly 1 cycle, err_timeout cleared, digit_cnt cleared, timeout counter cleared, go to KERNEL.
  - KERNEL:
    - Every uart_rx_valid restarts the timeout counter.
    - A byte in 0x30..0x39 increments digit_cnt (0..9); any other byte is forwarded but not counted.
    - When the 9th digit is counted, go to COMPUTE on the next cycle.
    - Timeout counter reaching TIMEOUT_CYCLES-1 with no byte: set err_timeout, go to RESTART.
    - A byte arriving in the same cycle as expiry wins: it is counted, and the counter restarts.
  - COMPUTE:
    - Wait for eng_print_enable == 1.
    - On that cycle: latch eng_cycles into cyc_reg, pulse prt_start for 1 cycle, go to PRINT.
  - PRINT:
    - Wait for prt_done.
    - On prt_done: eng_print_done = 1 for 1 cycle, go to CONVERT.
  - CONVERT:
    - Converts cyc_reg to 5 ASCII digits by repeated subtraction of 10000, 1000, 100 and 10; the remainder is the units digit.
    - At most 1 subtraction per cycle; completes in at most 40 cycles.
    - Then go to SEND.
  - SEND:
    - Transmits 7 bytes in order: 5 digits, most significant first, leading zeros kept; then 0x0D; then 0x0A.
    - tx_valid stays high and tx_data stays stable until tx_ready is seen; the next byte is presented on the following cycle.
    - After the 7th byte is accepted, go to RESTART.
  - RESTART:
    - eng_rst held high for RST_PULSE cycles, then go to IDLE.
    - run_done pulses on the IDLE entry only when err_timeout == 0.
- start outside IDLE is ignored; start asserted in the same cycle as entering IDLE is not accepted until the next cycle.
- prt_done or eng_print_enable outside their waiting states is ignored.
- Asynchronous reset mid-run returns to IDLE immediately with all outputs 0. eng_rst is not asserted by this path; the engine shares rst.
- Widths:
  - digit_cnt is 4 bits.
  - Timeout counter is wide enough for TIMEOUT_CYCLES.
  - cyc_reg is 16 bits; the full range 0..65535 converts correctly.

Test Plan:
- start, send "1 2 3 4 5 6 7 8 9" (17 bytes) -> eng_enable exactly 1 pulse; eng_rx_valid mirrors all 17 bytes; COMPUTE entered 1 cycle after the byte '9'.
- In COMPUTE, drive eng_print_enable with eng_cycles = 123 -> 1 prt_start pulse; after prt_done, 1 eng_print_done pulse; TX sends 0x30 0x30 0x31 0x32 0x33 0x0D 0x0A; then eng_rst high 2 cycles; then run_done 1 pulse.
- eng_cycles = 65535 with tx_ready toggling randomly -> bytes "65535\r\n" each held stable until accepted; no byte dropped or duplicated.
- TIMEOUT_CYCLES = 100, send 4 digits then stop -> err_timeout = 1 exactly 100 cycles after the last byte; eng_rst pulse; no run_done; next start clears err_timeout.
- uart_rx_valid pulses while in IDLE or COMPUTE -> eng_rx_valid stays 0; start pulses during SEND -> ignored.
- Assert rst during SEND -> all outputs 0 immediately; state IDLE; a fresh run afterwards completes normally.

Source files
------------

// File: rtl/conv_run_controller_if.sv
// Signal bundle between conv_run_controller and its surroundings.
//   start            run request
//   uart_rx_valid/_data   received UART byte
//   eng_*            convolution engine control, byte feed, print handshake, cycle count
//   prt_start/done   matrix printer handshake
//   tx_valid/data/ready   UART TX byte stream
//   busy/run_done/err_timeout  status
// The slave modport is the controller's view; master is the environment's view.
interface conv_run_controller_if;
  logic        start;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        eng_rst;
  logic        eng_enable;
  logic        eng_rx_valid;
  logic [7:0]  eng_rx_data;
  logic        eng_print_enable;
  logic        eng_print_done;
  logic [15:0] eng_cycles;
  logic        prt_start;
  logic        prt_done;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        run_done;
  logic        err_timeout;

  modport slave (
    input  start, uart_rx_valid, uart_rx_data, eng_print_enable, eng_cycles, prt_done, tx_ready,
    output eng_rst, eng_enable, eng_rx_valid, eng_rx_data, eng_print_done, prt_start,
    output tx_valid, tx_data, busy, run_done, err_timeout
  );

  modport master (
    output start, uart_rx_valid, uart_rx_data, eng_print_enable, eng_cycles, prt_done, tx_ready,
    input  eng_rst, eng_enable, eng_rx_valid, eng_rx_data, eng_print_done, prt_start,
    input  tx_valid, tx_data, busy, run_done, err_timeout
  );
endinterface

// File: rtl/conv_run_controller.sv
// Sequencer for one convolution run: arms the engine, gates UART kernel bytes to it while the
// kernel loads, hands the result print to the matrix printer, sends the engine cycle count as
// "DDDDD\r\n" over UART TX, then soft-resets the engine. A stalled kernel load aborts on timeout.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   bus_io  conv_run_controller_if.slave (see interface file for the signal list)
module conv_run_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned RST_PULSE      = 2
) (
  input logic                 clk,
  input logic                 rst,
  conv_run_controller_if.slave bus_io
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RstW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  typedef enum logic [2:0] {
    StIdle, StKernel, StCompute, StPrint, StConvert, StSend, StRestart
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        digit_cnt_q, digit_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [15:0]       cyc_q, cyc_d;
  logic [15:0]       rem_q, rem_d;
  logic [1:0]        pos_q, pos_d;
  logic [4:0][3:0]   dig_q, dig_d;
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;

  logic       eng_rst_q, eng_rst_d;
  logic       eng_enable_q, eng_enable_d;
  logic       eng_print_done_q, eng_print_done_d;
  logic       prt_start_q, prt_start_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       busy_q, busy_d;
  logic       run_done_q, run_done_d;
  logic       err_timeout_q, err_timeout_d;

  logic       rx_is_digit;

  // Decimal place weight for digit positions 0..3 (ten-thousands down to tens).
  function automatic logic [15:0] weight(input logic [1:0] pos);
    case (pos)
      2'd0:    weight = 16'd10000;
      2'd1:    weight = 16'd1000;
      2'd2:    weight = 16'd100;
      default: weight = 16'd10;
    endcase
  endfunction

  // Byte idx of the TX frame: five ASCII digits, then CR, then LF.
  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [4:0][3:0] digs);
    case (idx)
      3'd5:    tx_byte = 8'h0D;
      3'd6:    tx_byte = 8'h0A;
      default: tx_byte = {4'h3, digs[idx]};
    endcase
  endfunction

  assign rx_is_digit = (bus_io.uart_rx_data >= 8'h30) && (bus_io.uart_rx_data <= 8'h39);

  // Kernel bytes reach the engine only while loading.
  assign bus_io.eng_rx_valid = bus_io.uart_rx_valid && (state_q == StKernel);
  assign bus_io.eng_rx_data  = bus_io.uart_rx_data;

  assign bus_io.eng_rst        = eng_rst_q;
  assign bus_io.eng_enable     = eng_enable_q;
  assign bus_io.eng_print_done = eng_print_done_q;
  assign bus_io.prt_start      = prt_start_q;
  assign bus_io.tx_valid       = tx_valid_q;
  assign bus_io.tx_data        = tx_data_q;
  assign bus_io.busy           = busy_q;
  assign bus_io.run_done       = run_done_q;
  assign bus_io.err_timeout    = err_timeout_q;

  always_comb begin
    state_d          = state_q;
    digit_cnt_d      = digit_cnt_q;
    tmo_d            = tmo_q;
    cyc_d            = cyc_q;
    rem_d            = rem_q;
    pos_d            = pos_q;
    dig_d            = dig_q;
    tx_idx_d         = tx_idx_q;
    rst_cnt_d        = rst_cnt_q;
    eng_rst_d        = 1'b0;
    eng_enable_d     = 1'b0;
    eng_print_done_d = 1'b0;
    prt_start_d      = 1'b0;
    run_done_d       = 1'b0;
    tx_valid_d       = tx_valid_q;
    tx_data_d        = tx_data_q;
    err_timeout_d    = err_timeout_q;

    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          eng_enable_d  = 1'b1;
          err_timeout_d = 1'b0;
          digit_cnt_d   = '0;
          tmo_d         = '0;
          state_d       = StKernel;
        end
      end
      StKernel: begin
        // A byte in the expiry cycle takes priority over the timeout.
        if (bus_io.uart_rx_valid) begin
          tmo_d = '0;
          if (rx_is_digit) begin
            digit_cnt_d = digit_cnt_q + 4'd1;
            if (digit_cnt_q == 4'd8) state_d = StCompute;
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          eng_rst_d     = 1'b1;
          rst_cnt_d     = '0;
          state_d       = StRestart;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCompute: begin
        if (bus_io.eng_print_enable) begin
          cyc_d       = bus_io.eng_cycles;
          prt_start_d = 1'b1;
          state_d     = StPrint;
        end
      end
      StPrint: begin
        if (bus_io.prt_done) begin
          eng_print_done_d = 1'b1;
          rem_d            = cyc_q;
          pos_d            = '0;
          dig_d            = '0;
          state_d          = StConvert;
        end
      end
      StConvert: begin
        // One subtraction or one position advance per cycle.
        if (rem_q >= weight(pos_q)) begin
          rem_d              = rem_q - weight(pos_q);
          dig_d[{1'b0, pos_q}] = dig_q[{1'b0, pos_q}] + 4'd1;
        end else if (pos_q != 2'd3) begin
          pos_d = pos_q + 2'd1;
        end else begin
          dig_d[4]   = rem_q[3:0];
          tx_idx_d   = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = {4'h3, dig_q[0]};
          state_d    = StSend;
        end
      end
      StSend: begin
        if (bus_io.tx_ready) begin
          if (tx_idx_q == 3'd6) begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            eng_rst_d  = 1'b1;
            rst_cnt_d  = '0;
            state_d    = StRestart;
          end else begin
            tx_idx_d  = tx_idx_q + 3'd1;
            tx_data_d = tx_byte(tx_idx_q + 3'd1, dig_q);
          end
        end
      end
      StRestart: begin
        if (rst_cnt_q == RstW'(RST_PULSE - 1)) begin
          run_done_d = !err_timeout_q;
          state_d    = StIdle;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
          eng_rst_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      digit_cnt_q      <= '0;
      tmo_q            <= '0;
      cyc_q            <= '0;
      rem_q            <= '0;
      pos_q            <= '0;
      dig_q            <= '0;
      tx_idx_q         <= '0;
      rst_cnt_q        <= '0;
      eng_rst_q        <= 1'b0;
      eng_enable_q     <= 1'b0;
      eng_print_done_q <= 1'b0;
      prt_start_q      <= 1'b0;
      tx_valid_q       <= 1'b0;
      tx_data_q        <= '0;
      busy_q           <= 1'b0;
      run_done_q       <= 1'b0;
      err_timeout_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      digit_cnt_q      <= digit_cnt_d;
      tmo_q            <= tmo_d;
      cyc_q            <= cyc_d;
      rem_q            <= rem_d;
      pos_q            <= pos_d;
      dig_q            <= dig_d;
      tx_idx_q         <= tx_idx_d;
      rst_cnt_q        <= rst_cnt_d;
      eng_rst_q        <= eng_rst_d;
      eng_enable_q     <= eng_enable_d;
      eng_print_done_q <= eng_print_done_d;
      prt_start_q      <= prt_start_d;
      tx_valid_q       <= tx_valid_d;
      tx_data_q        <= tx_data_d;
      busy_q           <= busy_d;
      run_done_q       <= run_done_d;
      err_timeout_q    <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_conv_run_controller.sv
// Directed-plus-random bench for conv_run_controller. Expected TX frames come from formatting
// the cycle count as a decimal string; pulse counts and timings come from the run rules.
module tb_conv_run_controller;
  localparam int unsigned Tmo  = 100;
  localparam int unsigned RstP = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  conv_run_controller_if bus ();

  conv_run_controller #(
    .TIMEOUT_CYCLES(Tmo),
    .RST_PULSE     (RstP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Event monitor: only writer of these counters.
  int unsigned cyc = 0, n_en = 0, n_rx = 0, rx_bad = 0, n_prt = 0, n_pd = 0;
  int unsigned n_rst = 0, n_done = 0, viol = 0, last_rst_cyc = 0, done_cyc = 0;
  logic [7:0]  txq[$];
  logic        hold_pend = 1'b0;
  logic [7:0]  held = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.eng_enable) n_en <= n_en + 1;
    if (bus.eng_rx_valid) begin
      n_rx <= n_rx + 1;
      if (bus.eng_rx_data !== bus.uart_rx_data) rx_bad <= rx_bad + 1;
    end
    if (bus.prt_start) n_prt <= n_prt + 1;
    if (bus.eng_print_done) n_pd <= n_pd + 1;
    if (bus.eng_rst) begin
      n_rst        <= n_rst + 1;
      last_rst_cyc <= cyc;
    end
    if (bus.run_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    if (!rst && hold_pend && (!bus.tx_valid || bus.tx_data !== held)) viol <= viol + 1;
    hold_pend <= !rst && bus.tx_valid && !bus.tx_ready;
    held      <= bus.tx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {bus.eng_rst, bus.eng_enable, bus.eng_rx_valid, bus.eng_print_done, bus.prt_start,
            bus.tx_valid, bus.tx_data, bus.busy, bus.run_done, bus.err_timeout};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = b;
    @(negedge clk);
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = 8'h00;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Start a run and load nine digits with separators; fixed=1 sends "1 2 3 4 5 6 7 8 9".
  task automatic start_and_load(input bit fixed);
    int unsigned b_en, b_rx, b_bad, nbytes;
    logic [7:0]  ch;
    b_en = n_en; b_rx = n_rx; b_bad = rx_bad; nbytes = 0;
    pulse_start();
    chk("err_clear_on_start", {31'd0, bus.err_timeout}, 32'd0);
    for (int d = 0; d < 9; d++) begin
      if (d > 0) begin
        ch = (fixed || $urandom_range(0, 1) == 0) ? 8'h20 : 8'h2C;
        send_byte(ch);
        nbytes++;
        if (!fixed) tick($urandom_range(0, 3));
      end
      ch = fixed ? 8'h31 + 8'(d) : 8'h30 + 8'($urandom_range(0, 9));
      send_byte(ch);
      nbytes++;
    end
    // Immediately after the ninth digit the controller must already be past loading.
    send_byte(8'h41);
    chk("eng_enable_pulses", n_en - b_en, 32'd1);
    chk("eng_rx_mirror_count", n_rx - b_rx, nbytes);
    chk("eng_rx_data_bad", rx_bad - b_bad, 32'd0);
    chk("busy_in_compute", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic compute_print(input logic [15:0] cv);
    int unsigned b_prt, b_pd;
    b_prt = n_prt; b_pd = n_pd;
    bus.prt_done = 1'b1;  // ignored outside PRINT
    tick(1);
    bus.prt_done = 1'b0;
    tick($urandom_range(0, 5));
    bus.eng_cycles       = cv;
    bus.eng_print_enable = 1'b1;
    tick(1);
    bus.eng_print_enable = 1'b0;
    bus.eng_cycles       = 16'($urandom);
    tick(3);
    chk("prt_start_pulses", n_prt - b_prt, 32'd1);
    chk("print_done_early", n_pd - b_pd, 32'd0);
    bus.eng_print_enable = 1'b1;  // ignored outside COMPUTE
    tick(1);
    bus.eng_print_enable = 1'b0;
    bus.prt_done = 1'b1;
    tick(1);
    bus.prt_done = 1'b0;
    tick(1);
    chk("print_done_pulses", n_pd - b_pd, 32'd1);
    chk("prt_start_once", n_prt - b_prt, 32'd1);
  endtask

  task automatic send_phase(input logic [15:0] cv, input bit rnd_ready, input bit noise);
    string       s;
    int unsigned base, b_done, b_en, b_rst, b_viol;
    logic [7:0]  eb, ob;
    base = txq.size(); b_done = n_done; b_en = n_en; b_rst = n_rst; b_viol = viol;
    s = $sformatf("%05d\r\n", cv);
    for (int i = 0; i < 600 && n_done == b_done; i++) begin
      bus.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.start    = noise && bus.tx_valid && ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
    bus.start    = 1'b0;
    chk("tx_byte_count", txq.size() - base, 32'd7);
    for (int i = 0; i < 7; i++) begin
      eb = s[i];
      ob = (base + i < txq.size()) ? txq[base + i] : 8'hxx;
      chk($sformatf("tx_byte_%0d_of_%0d", i, cv), {24'd0, ob}, {24'd0, eb});
    end
    chk("tx_stable_while_stalled", viol - b_viol, 32'd0);
    chk("run_done_pulses", n_done - b_done, 32'd1);
    chk("eng_rst_cycles", n_rst - b_rst, RstP);
    chk("run_done_after_eng_rst", done_cyc, last_rst_cyc + 1);
    chk("start_ignored_while_busy", n_en - b_en, 32'd0);
    chk("err_timeout_clear", {31'd0, bus.err_timeout}, 32'd0);
    chk("busy_after_run", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic full_run(input logic [15:0] cv, input bit fixed, input bit rnd_ready,
                          input bit noise);
    start_and_load(fixed);
    compute_print(cv);
    send_phase(cv, rnd_ready, noise);
  endtask

  initial begin
    int unsigned b_rx, b_rst, b_done;
    logic [15:0] cv;
    bus.start = 1'b0; bus.uart_rx_valid = 1'b0; bus.uart_rx_data = 8'h00;
    bus.eng_print_enable = 1'b0; bus.eng_cycles = 16'h0000; bus.prt_done = 1'b0;
    bus.tx_ready = 1'b0;

    #2 rst = 1'b1;
    #1 chk("reset_outputs", {15'd0, outs()}, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("idle_outputs", {15'd0, outs()}, 32'd0);

    // Bytes while idle must not reach the engine.
    b_rx = n_rx;
    send_byte(8'h35);
    send_byte(8'h20);
    send_byte(8'h37);
    tick(1);
    chk("rx_gated_in_idle", n_rx - b_rx, 32'd0);

    full_run(16'd123, 1'b1, 1'b0, 1'b0);
    full_run(16'd65535, 1'b0, 1'b1, 1'b1);
    full_run(16'd0, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      cv = 16'($urandom);
      full_run(cv, 1'b0, 1'b1, 1'b1);
    end

    // Stalled kernel load: four digits, then silence.
    b_rst = n_rst; b_done = n_done;
    pulse_start();
    for (int d = 0; d < 4; d++) begin
      tick($urandom_range(0, 3));
      send_byte(8'h30 + 8'($urandom_range(0, 9)));
    end
    tick(Tmo - 1);
    chk("no_timeout_before_limit", {31'd0, bus.err_timeout}, 32'd0);
    tick(1);
    chk("timeout_at_limit", {31'd0, bus.err_timeout}, 32'd1);
    tick(5);
    chk("timeout_eng_rst_cycles", n_rst - b_rst, RstP);
    chk("timeout_no_run_done", n_done - b_done, 32'd0);
    chk("timeout_idle", {31'd0, bus.busy}, 32'd0);
    chk("timeout_sticky", {31'd0, bus.err_timeout}, 32'd1);
    full_run(16'($urandom), 1'b0, 1'b1, 1'b0);

    // Reset in the middle of SEND, then a clean run.
    start_and_load(1'b0);
    compute_print(16'd40960);
    for (int i = 0; i < 100 && !bus.tx_valid; i++) @(negedge clk);
    chk("reached_send", {31'd0, bus.tx_valid}, 32'd1);
    b_rst = n_rst;
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {15'd0, outs()}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("post_reset_outputs", {15'd0, outs()}, 32'd0);
    chk("no_eng_rst_on_reset", n_rst - b_rst, 32'd0);
    full_run(16'($urandom), 1'b0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
